// File: rtl/axi_master_pkg.sv
// Shared types and constants for the single-outstanding AXI4 burst initiator.
package axi_master_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WRESP = 3'd2,
      READ  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Larger encoding wins, so SLVERR/DECERR dominate OKAY/EXOKAY.
   function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] w;
      if (a > b) begin
         w = a;
      end else begin
         w = b;
      end
      return w;
   endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: one command becomes one INCR burst, one transaction
// outstanding at a time. Write beats stream in from wr_*, read beats stream
// out on rd_*, and done/done_resp report completion with the worst response.
// Optional build macro AXI_MASTER_RLAST_CHECK_EN: count read beats, flag an
// early or missing rlast as SLVERR and end the read at the counted last beat.
module axi_burst_master
   import axi_master_pkg::*;
#(
   parameter  int G_DATAWIDTH = 32,
   parameter  int G_ADDRWIDTH = 10,
   parameter  int G_ID_WIDTH  = 4,
   parameter  int G_ID        = 0,
   localparam int G_WEWIDTH   = ((G_DATAWIDTH-1)/8)+1
)(
   input  logic                   s_aclk,
   input  logic                   s_aresetn,
   // command
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [G_ADDRWIDTH-1:0] cmd_addr,
   input  logic [7:0]             cmd_len,
   // write beat source
   input  logic [G_DATAWIDTH-1:0] wr_data,
   input  logic [G_WEWIDTH-1:0]   wr_strb,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   // read beat sink
   output logic [G_DATAWIDTH-1:0] rd_data,
   output logic                   rd_last,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   // status
   output logic                   done,
   output logic [1:0]             done_resp,
   output logic                   busy,
   // AXI4 write address
   output logic [G_ID_WIDTH-1:0]  m_axi_awid,
   output logic [G_ADDRWIDTH-1:0] m_axi_awaddr,
   output logic [7:0]             m_axi_awlen,
   output logic [2:0]             m_axi_awsize,
   output logic [1:0]             m_axi_awburst,
   output logic                   m_axi_awvalid,
   input  logic                   m_axi_awready,
   // AXI4 write data
   output logic [G_DATAWIDTH-1:0] m_axi_wdata,
   output logic [G_WEWIDTH-1:0]   m_axi_wstrb,
   output logic                   m_axi_wlast,
   output logic                   m_axi_wvalid,
   input  logic                   m_axi_wready,
   // AXI4 write response
   input  logic [G_ID_WIDTH-1:0]  m_axi_bid,
   input  logic [1:0]             m_axi_bresp,
   input  logic                   m_axi_bvalid,
   output logic                   m_axi_bready,
   // AXI4 read address
   output logic [G_ID_WIDTH-1:0]  m_axi_arid,
   output logic [G_ADDRWIDTH-1:0] m_axi_araddr,
   output logic [7:0]             m_axi_arlen,
   output logic [2:0]             m_axi_arsize,
   output logic [1:0]             m_axi_arburst,
   output logic                   m_axi_arvalid,
   input  logic                   m_axi_arready,
   // AXI4 read data
   input  logic [G_ID_WIDTH-1:0]  m_axi_rid,
   input  logic [G_DATAWIDTH-1:0] m_axi_rdata,
   input  logic [1:0]             m_axi_rresp,
   input  logic                   m_axi_rlast,
   input  logic                   m_axi_rvalid,
   output logic                   m_axi_rready
);

   localparam logic [2:0]            C_AXSIZE = 3'($clog2(G_WEWIDTH));
   localparam logic [G_ID_WIDTH-1:0] C_ID     = G_ID_WIDTH'(G_ID);

   state_t                 state_r;
   logic [G_ADDRWIDTH-1:0] addr_r;
   logic [7:0]             len_r;
   logic [8:0]             cnt_r;      // 9 bits so len=255 reaches 256 beats
   logic                   aw_done_r;
   logic                   w_done_r;
   logic [1:0]             resp_r;
   logic                   done_r;
   logic                   busy_r;
   logic                   cmd_ready_r;
   logic                   awvalid_r;
   logic                   arvalid_r;

   logic                   in_write_s;
   logic                   in_read_s;
   logic                   last_beat_s;
   logic                   aw_hs_s;
   logic                   w_hs_s;
   logic                   ar_hs_s;
   logic                   r_hs_s;
   logic                   r_final_s;
   logic [1:0]             r_beat_resp_s;
   logic                   unused_id_s;

   // W is only offered until the last beat has been taken, even if AW lags.
   assign in_write_s  = (state_r == WRITE) && !w_done_r;
   assign in_read_s   = (state_r == READ);
   assign last_beat_s = (cnt_r == {1'b0, len_r});
   assign aw_hs_s     = awvalid_r && m_axi_awready;
   assign w_hs_s      = in_write_s && wr_valid && m_axi_wready;
   assign ar_hs_s     = arvalid_r && m_axi_arready;
   assign r_hs_s      = in_read_s && m_axi_rvalid && rd_ready;

`ifdef AXI_MASTER_RLAST_CHECK_EN
   // rlast must coincide with the counted last beat; any disagreement is an error.
   assign r_final_s     = last_beat_s;
   assign r_beat_resp_s = (m_axi_rlast != last_beat_s) ?
                          resp_worst(m_axi_rresp, AXI_RESP_SLVERR) : m_axi_rresp;
`else
   assign r_final_s     = m_axi_rlast;
   assign r_beat_resp_s = m_axi_rresp;
`endif

   // Response IDs are not checked: the constant ID is the only one ever issued.
   assign unused_id_s = ^{m_axi_bid, m_axi_rid};

   assign cmd_ready     = cmd_ready_r;
   assign done          = done_r;
   assign done_resp     = resp_r;
   assign busy          = busy_r;

   assign m_axi_awid    = C_ID;
   assign m_axi_awaddr  = addr_r;
   assign m_axi_awlen   = len_r;
   assign m_axi_awsize  = C_AXSIZE;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awvalid = awvalid_r;

   assign m_axi_wdata   = wr_data;
   assign m_axi_wstrb   = wr_strb;
   assign m_axi_wlast   = last_beat_s;
   assign m_axi_wvalid  = in_write_s && wr_valid;
   assign wr_ready      = in_write_s && m_axi_wready;

   assign m_axi_bready  = (state_r == WRESP);

   assign m_axi_arid    = C_ID;
   assign m_axi_araddr  = addr_r;
   assign m_axi_arlen   = len_r;
   assign m_axi_arsize  = C_AXSIZE;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arvalid = arvalid_r;

   assign rd_data       = m_axi_rdata;
   assign rd_last       = in_read_s && m_axi_rlast;
   assign rd_valid      = in_read_s && m_axi_rvalid;
   assign m_axi_rready  = in_read_s && rd_ready;

   // Transaction FSM with beat counter, response accumulation and registered status.
   always_ff @(posedge s_aclk) begin
      if (!s_aresetn) begin
         state_r     <= IDLE;
         addr_r      <= '0;
         len_r       <= 8'd0;
         cnt_r       <= 9'd0;
         aw_done_r   <= 1'b0;
         w_done_r    <= 1'b0;
         resp_r      <= AXI_RESP_OKAY;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
         cmd_ready_r <= 1'b0;
         awvalid_r   <= 1'b0;
         arvalid_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cmd_ready_r <= 1'b1;
               if (cmd_valid && cmd_ready_r) begin
                  addr_r      <= cmd_addr;
                  len_r       <= cmd_len;
                  cnt_r       <= 9'd0;
                  aw_done_r   <= 1'b0;
                  w_done_r    <= 1'b0;
                  resp_r      <= AXI_RESP_OKAY;
                  busy_r      <= 1'b1;
                  cmd_ready_r <= 1'b0;
                  if (cmd_write) begin
                     awvalid_r <= 1'b1;
                     state_r   <= WRITE;
                  end else begin
                     arvalid_r <= 1'b1;
                     state_r   <= READ;
                  end
               end
            end
            WRITE: begin
               if (aw_hs_s) begin
                  awvalid_r <= 1'b0;
                  aw_done_r <= 1'b1;
               end
               if (w_hs_s) begin
                  cnt_r <= cnt_r + 9'd1;
                  if (last_beat_s) begin
                     w_done_r <= 1'b1;
                  end
               end
               if ((aw_done_r || aw_hs_s) && (w_done_r || (w_hs_s && last_beat_s))) begin
                  state_r <= WRESP;
               end
            end
            WRESP: begin
               if (m_axi_bvalid) begin
                  resp_r  <= resp_worst(resp_r, m_axi_bresp);
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end
            end
            READ: begin
               if (ar_hs_s) begin
                  arvalid_r <= 1'b0;
               end
               if (r_hs_s) begin
                  resp_r <= resp_worst(resp_r, r_beat_resp_s);
`ifdef AXI_MASTER_RLAST_CHECK_EN
                  cnt_r  <= cnt_r + 9'd1;
`endif
                  if (r_final_s) begin
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end
               end
            end
            DONE: begin
               busy_r      <= 1'b0;
               cmd_ready_r <= 1'b1;
               state_r     <= IDLE;
            end
            default: begin
               awvalid_r   <= 1'b0;
               arvalid_r   <= 1'b0;
               busy_r      <= 1'b0;
               cmd_ready_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a small axi_1p-style memory slave.
module tb_axi_burst_master;

   logic        s_aclk = 1'b0;
   logic        s_aresetn = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [9:0]  cmd_addr = 10'd0;
   logic [7:0]  cmd_len = 8'd0;
   logic [31:0] wr_data = 32'd0;
   logic [3:0]  wr_strb = 4'hF;
   logic        wr_valid = 1'b0, rd_ready = 1'b0;
   logic        cmd_ready, wr_ready, rd_last, rd_valid, done, busy;
   logic [31:0] rd_data;
   logic [1:0]  done_resp;
   logic [3:0]  m_axi_awid, m_axi_arid;
   logic [9:0]  m_axi_awaddr, m_axi_araddr;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_arsize;
   logic [1:0]  m_axi_awburst, m_axi_arburst;
   logic        m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;

   // slave model state
   logic        sl_awready, sl_wready, sl_arready, sl_bvalid, sl_rvalid, sl_rlast;
   logic [1:0]  sl_bresp, sl_rresp;
   logic [31:0] sl_rdata;
   logic        sl_aw_done, sl_w_done;
   logic [7:0]  sl_aw_base, sl_r_base;
   int          sl_wcnt, sl_rcnt, sl_r_len;
   logic [31:0] sl_wbuf_d [256];
   logic [3:0]  sl_wbuf_s [256];
   logic [31:0] mem [256];
   logic [31:0] wlog_d [1024];
   logic        wlog_l [1024];
   int          w_total;
   logic [9:0]  cap_awaddr, cap_araddr;
   logic [7:0]  cap_awlen, cap_arlen;
   logic [2:0]  cap_awsize, cap_arsize;
   logic [1:0]  cap_awburst, cap_arburst;
   logic [3:0]  cap_awid;
   // slave controls, written only by the stimulus block
   logic        sl_stall = 1'b0;
   logic [1:0]  sl_bresp_force = 2'b00;
   int          sl_early = -1;

   logic [31:0] wsrc  [256];
   logic [31:0] rcap  [512];
   logic        rlcap [512];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   axi_burst_master dut (
      .s_aclk(s_aclk), .s_aresetn(s_aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .done_resp(done_resp), .busy(busy),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(sl_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(sl_wready),
      .m_axi_bid(4'd0), .m_axi_bresp(sl_bresp), .m_axi_bvalid(sl_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(sl_arready),
      .m_axi_rid(4'd0), .m_axi_rdata(sl_rdata), .m_axi_rresp(sl_rresp), .m_axi_rlast(sl_rlast),
      .m_axi_rvalid(sl_rvalid), .m_axi_rready(m_axi_rready)
   );

   always #5 s_aclk = ~s_aclk;

   // cycle counter used for latency measurement
   always @(posedge s_aclk) cyc <= cyc + 1;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   // memory slave: registered readies, B one cycle after AW and last W, R from AR handshake
   always @(posedge s_aclk) begin
      if (!s_aresetn) begin
         sl_awready <= 1'b0; sl_wready <= 1'b0; sl_arready <= 1'b0;
         sl_bvalid <= 1'b0; sl_bresp <= 2'b00; sl_rvalid <= 1'b0; sl_rlast <= 1'b0;
         sl_rresp <= 2'b00; sl_rdata <= 32'd0;
         sl_aw_done <= 1'b0; sl_w_done <= 1'b0; sl_wcnt <= 0; sl_rcnt <= 0; sl_r_len <= 0;
         sl_aw_base <= 8'd0; sl_r_base <= 8'd0; w_total <= 0;
      end else begin
         sl_awready <= sl_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         sl_wready  <= sl_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         sl_arready <= sl_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_axi_awvalid && sl_awready) begin
            sl_aw_done <= 1'b1; sl_aw_base <= m_axi_awaddr[9:2];
            cap_awaddr <= m_axi_awaddr; cap_awlen <= m_axi_awlen; cap_awsize <= m_axi_awsize;
            cap_awburst <= m_axi_awburst; cap_awid <= m_axi_awid;
         end
         if (m_axi_wvalid && sl_wready) begin
            sl_wbuf_d[sl_wcnt] <= m_axi_wdata; sl_wbuf_s[sl_wcnt] <= m_axi_wstrb;
            sl_wcnt <= sl_wcnt + 1;
            wlog_d[w_total] <= m_axi_wdata; wlog_l[w_total] <= m_axi_wlast;
            w_total <= w_total + 1;
            if (m_axi_wlast) sl_w_done <= 1'b1;
         end
         if (sl_bvalid && m_axi_bready) begin
            sl_bvalid <= 1'b0; sl_aw_done <= 1'b0; sl_w_done <= 1'b0; sl_wcnt <= 0;
         end else if (sl_aw_done && sl_w_done && !sl_bvalid) begin
            sl_bvalid <= 1'b1; sl_bresp <= sl_bresp_force;
            for (int i = 0; i < 256; i++)
               if (i < sl_wcnt)
                  mem[8'(int'(sl_aw_base) + i)] <= merge(mem[8'(int'(sl_aw_base) + i)], sl_wbuf_d[i], sl_wbuf_s[i]);
         end
         if (m_axi_arvalid && sl_arready) begin
            sl_r_base <= m_axi_araddr[9:2]; sl_r_len <= int'(m_axi_arlen); sl_rcnt <= 0;
            sl_rvalid <= 1'b1; sl_rdata <= mem[m_axi_araddr[9:2]]; sl_rresp <= 2'b00;
            sl_rlast <= (m_axi_arlen == 8'd0) || (sl_early == 0);
            cap_araddr <= m_axi_araddr; cap_arlen <= m_axi_arlen; cap_arsize <= m_axi_arsize;
            cap_arburst <= m_axi_arburst;
         end else if (sl_rvalid && m_axi_rready) begin
            if (sl_rcnt == sl_r_len) begin
               sl_rvalid <= 1'b0; sl_rlast <= 1'b0;
            end else begin
               sl_rcnt  <= sl_rcnt + 1;
               sl_rdata <= mem[8'(int'(sl_r_base) + sl_rcnt + 1)];
               sl_rlast <= ((sl_rcnt + 1) == sl_r_len) || ((sl_rcnt + 1) == sl_early);
            end
         end
      end
   end

   task automatic apply_reset(input int n);
      @(negedge s_aclk); s_aresetn = 1'b0;
      repeat (n) @(negedge s_aclk);
      s_aresetn = 1'b1;
   endtask

   // Runs one command to completion. lat = cycles from the accept cycle to the done cycle.
   task automatic do_cmd(input logic wr, input logic [9:0] addr, input logic [7:0] len,
                         input int wgap, input int rgap,
                         output int lat, output logic [1:0] resp, output int nrd,
                         output int bcnt, output logic to);
      int wi; int t0; int n; logic acc; logic w_hs; logic r_hs;
      wi = 0; t0 = 0; n = 0; acc = 1'b0; lat = -1; resp = 2'b00; nrd = 0; bcnt = 0; to = 1'b0;
      @(negedge s_aclk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      wr_valid = wr; wr_data = wsrc[0]; wr_strb = 4'hF; rd_ready = !wr;
      forever begin
         #1;
         if (busy) bcnt++;
         if (done) begin lat = cyc - t0; resp = done_resp; break; end
         if (cmd_valid && cmd_ready && !acc) begin acc = 1'b1; t0 = cyc; end
         w_hs = wr_valid && wr_ready;
         r_hs = rd_valid && rd_ready;
         if (r_hs && nrd < 512) begin rcap[nrd] = rd_data; rlcap[nrd] = rd_last; nrd++; end
         if (n >= 3000) begin to = 1'b1; break; end
         @(negedge s_aclk); n++;
         if (acc) cmd_valid = 1'b0;
         if (w_hs) wi++;
         if (wr && !(wr_valid && !w_hs)) begin
            wr_valid = (wi <= int'(len)) && ($urandom_range(0, 99) >= wgap);
            if (wi <= int'(len)) wr_data = wsrc[wi];
         end
         if (!wr) rd_ready = ($urandom_range(0, 99) >= rgap);
      end
      cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge s_aclk); s_aresetn = 1'b0;
      @(posedge s_aclk); #1;
      checks++;
      if ({cmd_ready, busy, done, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rd_valid, rd_last} !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: got %b required 00000000",
                  {cmd_ready, busy, done, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rd_valid, rd_last});
      end
      repeat (2) @(negedge s_aclk);
      s_aresetn = 1'b1;
      @(posedge s_aclk); #1;
      checks++;
      if ({cmd_ready, busy} !== 2'b10) begin
         failures++; $display("FAIL reset_idle: cmd_ready,busy got %b required 10", {cmd_ready, busy});
      end
   endtask

   task automatic test_write_basic();
      int lat, nrd, bc, base; logic [1:0] resp; logic to; int errs;
      for (int i = 0; i < 4; i++) wsrc[i] = 32'hA0 + 32'(i);
      base = w_total;
      do_cmd(1'b1, 10'h010, 8'd3, 0, 0, lat, resp, nrd, bc, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL wr_timeout: got %b required 0", to); end
      checks++; if (lat !== 7) begin failures++; $display("FAIL wr_latency: got %0d required 7", lat); end
      checks++; if (resp !== 2'b00) begin failures++; $display("FAIL wr_resp: got %b required 00", resp); end
      checks++; if (bc !== 7) begin failures++; $display("FAIL wr_busy_cycles: got %0d required 7", bc); end
      checks++; if (w_total - base !== 4) begin failures++; $display("FAIL wr_beats: got %0d required 4", w_total - base); end
      errs = 0;
      for (int i = 0; i < 4; i++)
         if (wlog_d[base+i] !== 32'hA0 + 32'(i) || wlog_l[base+i] !== (i == 3)) errs++;
      checks++; if (errs !== 0) begin failures++; $display("FAIL wr_data_wlast: got %0d bad beats required 0", errs); end
      checks++;
      if ({cap_awaddr, cap_awlen, cap_awsize, cap_awburst, cap_awid} !== {10'h010, 8'd3, 3'd2, 2'b01, 4'd0}) begin
         failures++; $display("FAIL aw_fields: got %h %h %h %h %h required 010 03 2 1 0",
                              cap_awaddr, cap_awlen, cap_awsize, cap_awburst, cap_awid);
      end
      @(negedge s_aclk); #1;
      checks++;
      if ({done, busy, cmd_ready} !== 3'b001) begin
         failures++; $display("FAIL wr_after_done: done,busy,cmd_ready got %b required 001", {done, busy, cmd_ready});
      end
   endtask

   task automatic test_read_basic();
      int lat, nrd, bc, errs; logic [1:0] resp; logic to;
      do_cmd(1'b0, 10'h010, 8'd3, 0, 0, lat, resp, nrd, bc, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rd_timeout: got %b required 0", to); end
      checks++; if (lat !== 6) begin failures++; $display("FAIL rd_latency: got %0d required 6", lat); end
      checks++; if (resp !== 2'b00) begin failures++; $display("FAIL rd_resp: got %b required 00", resp); end
      checks++; if (nrd !== 4) begin failures++; $display("FAIL rd_beats: got %0d required 4", nrd); end
      errs = 0;
      for (int i = 0; i < 4; i++) if (rcap[i] !== 32'hA0 + 32'(i) || rlcap[i] !== (i == 3)) errs++;
      checks++; if (errs !== 0) begin failures++; $display("FAIL rd_data_last: got %0d bad beats required 0", errs); end
      checks++;
      if ({cap_araddr, cap_arlen, cap_arsize, cap_arburst} !== {10'h010, 8'd3, 3'd2, 2'b01}) begin
         failures++; $display("FAIL ar_fields: got %h %h %h %h required 010 03 2 1",
                              cap_araddr, cap_arlen, cap_arsize, cap_arburst);
      end
   endtask

   task automatic test_random_stalls();
      int lat, nrd, bc, base, errs; logic [1:0] resp; logic to;
      for (int i = 0; i < 16; i++) wsrc[i] = $urandom;
      sl_stall = 1'b1;
      base = w_total;
      do_cmd(1'b1, 10'h100, 8'd15, 40, 0, lat, resp, nrd, bc, to);
      checks++; if (to !== 1'b0 || resp !== 2'b00) begin failures++; $display("FAIL stall_wr_done: timeout %b resp %b required 0 00", to, resp); end
      checks++; if (w_total - base !== 16) begin failures++; $display("FAIL stall_wr_beats: got %0d required 16", w_total - base); end
      errs = 0;
      for (int i = 0; i < 16; i++) if (wlog_d[base+i] !== wsrc[i] || wlog_l[base+i] !== (i == 15)) errs++;
      checks++; if (errs !== 0) begin failures++; $display("FAIL stall_wr_data: got %0d bad beats required 0", errs); end
      do_cmd(1'b0, 10'h100, 8'd15, 0, 40, lat, resp, nrd, bc, to);
      checks++; if (to !== 1'b0 || nrd !== 16) begin failures++; $display("FAIL stall_rd_beats: got %0d timeout %b required 16 0", nrd, to); end
      errs = 0;
      for (int i = 0; i < 16; i++) if (rcap[i] !== wsrc[i] || rlcap[i] !== (i == 15)) errs++;
      checks++; if (errs !== 0) begin failures++; $display("FAIL stall_rd_data: got %0d bad beats required 0", errs); end
      sl_stall = 1'b0;
   endtask

   task automatic test_bresp_error();
      int lat, nrd, bc; logic [1:0] resp; logic to;
      wsrc[0] = 32'h1234_5678; wsrc[1] = 32'h9ABC_DEF0;
      sl_bresp_force = 2'b10;
      do_cmd(1'b1, 10'h040, 8'd1, 0, 0, lat, resp, nrd, bc, to);
      checks++; if (resp !== 2'b10 || to !== 1'b0) begin failures++; $display("FAIL bresp_slverr: got %b timeout %b required 10 0", resp, to); end
      sl_bresp_force = 2'b00;
      do_cmd(1'b0, 10'h040, 8'd1, 0, 0, lat, resp, nrd, bc, to);
      checks++; if (resp !== 2'b00) begin failures++; $display("FAIL resp_cleared: got %b required 00", resp); end
      checks++;
      if (nrd !== 2 || rcap[1] !== 32'h9ABC_DEF0) begin
         failures++; $display("FAIL bresp_readback: got %0d beats %h required 2 9abcdef0", nrd, rcap[1]);
      end
   endtask

   task automatic test_reset_mid_burst();
      int nb, n, lat, nrd, bc; logic acc; logic [1:0] resp; logic to;
      for (int i = 0; i < 8; i++) wsrc[i] = 32'h55 + 32'(i);
      nb = 0; n = 0; acc = 1'b0;
      @(negedge s_aclk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h080; cmd_len = 8'd7;
      wr_valid = 1'b1; wr_data = wsrc[0];
      while (nb < 2 && n < 50) begin
         #1;
         if (cmd_valid && cmd_ready) acc = 1'b1;
         if (wr_valid && wr_ready) nb++;
         @(negedge s_aclk); n++;
         if (acc) cmd_valid = 1'b0;
         wr_data = wsrc[nb];
      end
      checks++; if (nb !== 2) begin failures++; $display("FAIL midrst_beats: got %0d required 2", nb); end
      s_aresetn = 1'b0;
      @(posedge s_aclk); #1;
      checks++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, busy, done} !== 6'b0) begin
         failures++; $display("FAIL midrst_valids: got %b required 000000",
                              {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, busy, done});
      end
      @(negedge s_aclk); wr_valid = 1'b0; s_aresetn = 1'b1;
      repeat (2) @(negedge s_aclk);
      #1;
      checks++; if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL midrst_idle: got %b required 10", {cmd_ready, busy}); end
      wsrc[0] = 32'hFEED_0001;
      do_cmd(1'b1, 10'h0C0, 8'd0, 0, 0, lat, resp, nrd, bc, to);
      checks++;
      if (to !== 1'b0 || lat !== 4 || resp !== 2'b00) begin
         failures++; $display("FAIL midrst_fresh: timeout %b latency %0d resp %b required 0 4 00", to, lat, resp);
      end
   endtask

   task automatic test_rlast_early();
      int lat, nrd, bc; logic [1:0] resp; logic to;
      sl_early = 1;
      do_cmd(1'b0, 10'h010, 8'd3, 0, 0, lat, resp, nrd, bc, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL early_timeout: got %b required 0", to); end
`ifdef AXI_MASTER_RLAST_CHECK_EN
      checks++; if (resp !== 2'b10) begin failures++; $display("FAIL early_resp: got %b required 10", resp); end
      checks++; if (nrd !== 4) begin failures++; $display("FAIL early_beats: got %0d required 4", nrd); end
`else
      checks++; if (resp !== 2'b00) begin failures++; $display("FAIL early_resp: got %b required 00", resp); end
      checks++;
      if (nrd !== 2 || rcap[1] !== 32'hA1 || rlcap[1] !== 1'b1) begin
         failures++; $display("FAIL early_beats: got %0d beats %h last %b required 2 a1 1", nrd, rcap[1], rlcap[1]);
      end
`endif
      sl_early = -1;
      apply_reset(2);
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_random_stalls();
      test_bresp_error();
      test_reset_mid_burst();
      test_rlast_early();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
